// File: rtl/inorder_release_tracker.sv
// In-order release tracker: tail allocation, out-of-order completion by tag, contiguous head release.
// Optional macro INORDER_RELEASE_TRACKER_DONE_BYPASS_EN lets same-cycle completions feed the release mask.

module inorder_release_tracker_entry (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic alloc_i,
  input  logic alloc_flag_i,
  input  logic done_i,
  input  logic rel_i,
  output logic valid_o,
  output logic done_o,
  output logic flag_o
);
  logic valid_q, done_q, flag_q;

  // A slot is never allocated while valid, so alloc and rel/done cannot collide.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else if (alloc_i) begin
      valid_q <= 1'b1;
      done_q  <= 1'b0;
      flag_q  <= alloc_flag_i;
    end else if (rel_i) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (done_i) begin
      done_q  <= 1'b1;
    end
  end

  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign flag_o  = flag_q;
endmodule

module inorder_release_tracker #(
  parameter  int ENTRY_COUNT   = 8,
  parameter  int ALLOC_WIDTH   = 2,
  parameter  int DONE_WIDTH    = 2,
  parameter  int RELEASE_WIDTH = 2,
  localparam int PTR_W         = $clog2(ENTRY_COUNT),
  localparam int TAG_W         = PTR_W + 1,
  localparam int CNT_W         = $clog2(ENTRY_COUNT + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush_i,
  input  logic [ALLOC_WIDTH-1:0]                 alloc_fire_i,
  output logic                                   alloc_rdy_o,
  output logic [ALLOC_WIDTH-1:0][TAG_W-1:0]      alloc_tag_o,
  input  logic [DONE_WIDTH-1:0]                  done_valid_i,
  input  logic [DONE_WIDTH-1:0][TAG_W-1:0]       done_tag_i,
  input  logic                                   release_en_i,
  output logic [RELEASE_WIDTH-1:0]               release_fire_o,
  output logic [RELEASE_WIDTH-1:0][TAG_W-1:0]    release_tag_o,
  output logic [CNT_W-1:0]                       used_cnt_o,
  output logic                                   empty_o
);
  localparam logic [PTR_W+1:0] ENT_S   = (PTR_W+2)'(ENTRY_COUNT);
  localparam logic [CNT_W-1:0] RDY_MAX = CNT_W'(ENTRY_COUNT - ALLOC_WIDTH);

  // {flag, idx} + n with wrap at ENTRY_COUNT; flag toggles on wrap.
  function automatic logic [TAG_W-1:0] ptr_add(input logic [TAG_W-1:0] p, input logic [CNT_W-1:0] n);
    logic [PTR_W+1:0] sum;
    sum = (PTR_W+2)'(p[PTR_W-1:0]) + (PTR_W+2)'(n);
    if (sum >= ENT_S) ptr_add = {~p[PTR_W], PTR_W'(sum - ENT_S)};
    else              ptr_add = {p[PTR_W], sum[PTR_W-1:0]};
  endfunction

  logic [TAG_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       used_q, used_d;
  logic [CNT_W-1:0]       alloc_cnt, rel_cnt;
  logic                   alloc_ok;
  logic [ENTRY_COUNT-1:0] valid_q, done_q, flag_q;
  logic [ENTRY_COUNT-1:0] alloc_set, alloc_flag, done_set, done_eff, rel_clr;

  assign alloc_rdy_o = used_q <= RDY_MAX;
  assign alloc_ok    = alloc_rdy_o & ~flush_i;
  assign used_cnt_o  = used_q;
  assign empty_o     = used_q == '0;

  always_comb begin
    alloc_cnt = '0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      alloc_tag_o[k] = ptr_add(tail_q, alloc_cnt);
      alloc_cnt      = alloc_cnt + CNT_W'(alloc_fire_i[k]);
    end
    if (!alloc_ok) alloc_cnt = '0;
  end

  // Completion hits require a live slot whose stored flag matches the tag.
  always_comb begin
    alloc_set  = '0;
    alloc_flag = '0;
    done_set   = '0;
    for (int e = 0; e < ENTRY_COUNT; e++) begin
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
        if (alloc_ok && alloc_fire_i[k] && alloc_tag_o[k][PTR_W-1:0] == PTR_W'(e)) begin
          alloc_set[e]  = 1'b1;
          alloc_flag[e] = alloc_tag_o[k][PTR_W];
        end
      end
      for (int d = 0; d < DONE_WIDTH; d++) begin
        if (done_valid_i[d] && valid_q[e] && done_tag_i[d] == {flag_q[e], PTR_W'(e)})
          done_set[e] = 1'b1;
      end
    end
  end

`ifdef INORDER_RELEASE_TRACKER_DONE_BYPASS_EN
  assign done_eff = done_q | done_set;
`else
  assign done_eff = done_q;
`endif

  always_comb begin
    logic run, ok;
    run     = release_en_i & ~flush_i;
    rel_cnt = '0;
    rel_clr = '0;
    for (int i = 0; i < RELEASE_WIDTH; i++) begin
      release_tag_o[i] = ptr_add(head_q, CNT_W'(i));
      ok = 1'b0;
      for (int e = 0; e < ENTRY_COUNT; e++)
        if (release_tag_o[i][PTR_W-1:0] == PTR_W'(e)) ok = valid_q[e] & done_eff[e];
      run = run & ok;
      release_fire_o[i] = run;
      if (run) rel_cnt = rel_cnt + 1'b1;
      for (int e = 0; e < ENTRY_COUNT; e++)
        if (run && release_tag_o[i][PTR_W-1:0] == PTR_W'(e)) rel_clr[e] = 1'b1;
    end
  end

  always_comb begin
    head_d = ptr_add(head_q, rel_cnt);
    tail_d = ptr_add(tail_q, alloc_cnt);
    used_d = used_q + alloc_cnt - rel_cnt;
    if (flush_i) begin
      head_d = head_q;
      tail_d = head_q;
      used_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      used_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      used_q <= used_d;
    end
  end

  for (genvar e = 0; e < ENTRY_COUNT; e++) begin : g_entry
    inorder_release_tracker_entry u_entry (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .alloc_i     (alloc_set[e]),
      .alloc_flag_i(alloc_flag[e]),
      .done_i      (done_set[e]),
      .rel_i       (rel_clr[e]),
      .valid_o     (valid_q[e]),
      .done_o      (done_q[e]),
      .flag_o      (flag_q[e])
    );
  end
endmodule

// File: tb/tb_inorder_release_tracker.sv
// Random + directed bench for inorder_release_tracker (ENTRY_COUNT=6) against a sequence-number model.
module tb_inorder_release_tracker;
  localparam int E     = 6;
  localparam int AW    = 2;
  localparam int DW    = 2;
  localparam int RW    = 2;
  localparam int PTR_W = $clog2(E);
  localparam int TAG_W = PTR_W + 1;
  localparam int CNT_W = $clog2(E + 1);
`ifdef INORDER_RELEASE_TRACKER_DONE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         rst, flush, alloc_rdy, release_en, empty;
  logic [AW-1:0]                alloc_fire;
  logic [AW-1:0][TAG_W-1:0]     alloc_tag;
  logic [DW-1:0]                done_valid;
  logic [DW-1:0][TAG_W-1:0]     done_tag;
  logic [RW-1:0]                release_fire;
  logic [RW-1:0][TAG_W-1:0]     release_tag;
  logic [CNT_W-1:0]             used_cnt;

  always #5 clk = ~clk;

  inorder_release_tracker #(.ENTRY_COUNT(E), .ALLOC_WIDTH(AW), .DONE_WIDTH(DW), .RELEASE_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .alloc_fire_i(alloc_fire), .alloc_rdy_o(alloc_rdy), .alloc_tag_o(alloc_tag),
    .done_valid_i(done_valid), .done_tag_i(done_tag),
    .release_en_i(release_en), .release_fire_o(release_fire), .release_tag_o(release_tag),
    .used_cnt_o(used_cnt), .empty_o(empty)
  );

  int n_chk  = 0;
  int n_pass = 0;
  // Model: entries are monotonically numbered; live range is [head_s, tail_s).
  int head_s = 0;
  int tail_s = 0;
  bit done_m[int];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int tagof(input int s);
    return ((s / E) % 2) * (1 << PTR_W) + (s % E);
  endfunction

  function automatic int pick();
    int r;
    r = int'($urandom_range(99, 0));
    if (r < 30 && tail_s > head_s) return tagof(head_s);
    if (r < 70 && tail_s > head_s) return tagof(head_s + int'($urandom_range(tail_s - head_s - 1, 0)));
    if (r < 85 && head_s >= 3) return tagof(head_s - 1 - int'($urandom_range(2, 0)));
    return int'($urandom_range((1 << TAG_W) - 1, 0));
  endfunction

  task automatic step(input logic [AW-1:0] af, input logic [DW-1:0] dv, input int t0, input int t1,
                      input logic ren, input logic fl, input logic rs);
    int dt[DW];
    int hit[DW];
    int used, nrel, nalloc, acc, s;
    logic run, ok, rdy;
    dt[0] = t0;
    dt[1] = t1;
    @(negedge clk);
    rst = rs; flush = fl; alloc_fire = af; release_en = ren; done_valid = dv;
    for (int d = 0; d < DW; d++) done_tag[d] = TAG_W'(dt[d]);
    #1;
    for (int d = 0; d < DW; d++) begin
      hit[d] = -1;
      if (dv[d])
        for (int q = head_s; q < tail_s; q++) if (tagof(q) == dt[d]) hit[d] = q;
    end
    used = tail_s - head_s;
    rdy  = used <= E - AW;
    run  = ren & !fl;
    nrel = 0;
    for (int i = 0; i < RW; i++) begin
      s   = head_s + i;
      ok  = (s < tail_s) && (done_m.exists(s) || (BYP && (hit[0] == s || hit[1] == s)));
      run = run & ok;
      if (run) nrel++;
      if (!rs) begin
        chk($sformatf("rel_fire%0d", i), int'(release_fire[i]), int'(run));
        chk($sformatf("rel_tag%0d", i), int'(release_tag[i]), tagof(s));
      end
    end
    acc = 0;
    for (int k = 0; k < AW; k++) begin
      if (!rs) chk($sformatf("alloc_tag%0d", k), int'(alloc_tag[k]), tagof(tail_s + acc));
      acc += int'(af[k]);
    end
    nalloc = (rdy && !fl) ? acc : 0;
    if (!rs) begin
      chk("used_cnt", int'(used_cnt), used);
      chk("empty", int'(empty), int'(used == 0));
      chk("alloc_rdy", int'(alloc_rdy), int'(rdy));
    end
    @(posedge clk);
    if (rs) begin
      head_s = 0; tail_s = 0; done_m.delete();
    end else if (fl) begin
      tail_s = head_s; done_m.delete();
    end else begin
      for (int d = 0; d < DW; d++) if (hit[d] >= 0) done_m[hit[d]] = 1'b1;
      for (int i = 0; i < nrel; i++) done_m.delete(head_s + i);
      head_s += nrel;
      tail_s += nalloc;
    end
  endtask

  initial begin
    int o1, o2;
    rst = 1'b1; flush = 1'b0; alloc_fire = '0; done_valid = '0; done_tag = '0; release_en = 1'b0;
    step(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    step(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rst_used", int'(used_cnt), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_rdy", int'(alloc_rdy), 1);
    chk("rst_fire", int'(release_fire), 0);

    // Fill all six slots, then an over-fire that must be ignored.
    repeat (3) step(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("full_used", int'(used_cnt), 6);
    chk("full_rdy", int'(alloc_rdy), 0);
    chk("full_tail_tag", int'(alloc_tag[0]), 8);
    step(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("overfire_used", int'(used_cnt), 6);

    // Out-of-order completions, then the head.
    step(2'b00, 2'b11, 3, 2, 1'b1, 1'b0, 1'b0);
    step(2'b00, 2'b01, 1, 0, 1'b1, 1'b0, 1'b0);
    step(2'b00, 2'b01, 0, 0, 1'b1, 1'b0, 1'b0);
    repeat (3) step(2'b00, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("drain_used", int'(used_cnt), 2);

    // Flush with entries live and completions pending; old tags must stay dead.
    step(2'b11, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    o1 = tagof(head_s);
    o2 = tagof(head_s + 1);
    step(2'b00, 2'b11, o1, o2, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush_used", int'(used_cnt), 0);
    chk("flush_empty", int'(empty), 1);
    step(2'b00, 2'b11, o1, o2, 1'b1, 1'b0, 1'b0);

    // Alloc one and release one in the same cycle.
    step(2'b01, 2'b00, 0, 0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b01, tagof(head_s), 0, 1'b0, 1'b0, 1'b0);
    step(2'b01, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("alloc_rel_used", int'(used_cnt), 1);

    for (int c = 0; c < 3000; c++) begin
      int t0, t1;
      t0 = pick();
      t1 = pick();
      step(AW'($urandom), DW'($urandom), t0, t1, ($urandom_range(3, 0) != 0),
           ($urandom_range(39, 0) == 0), (c == 1500));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
